// File: rtl/pc_controller.sv
// -----------------------------------------------------------------------------
// pc_controller
//
// Program-counter sequencer for the single-cycle MIPS core. Each cycle it
// picks the next fetch address from the exception vector, the interrupt
// vector, a jr target, a j target, a branch target or the sequential address.
// Kernel mode is carried in PC[31]. The block latches timer interrupts and
// produces the $k0/$k1 return-address write for the register file.
//
// Optional build macro: PC_CTRL_IRQ_COUNT_EN
//   When defined, the block adds a saturating taken-interrupt counter
//   (IRQCount) and a sticky lost-interrupt flag (IRQLost).
//
// Ports:
//   clk          core clock
//   reset        synchronous, active-low reset
//   Stall        hold PC and Cause; only the IRQ latch keeps updating
//   Branch       conditional branch taken
//   Imm16        branch offset, in words, sign-extended
//   Jump         j/jal
//   Target26     jump field
//   JumpReg      jr/jalr
//   RegTarget    rs value for jr
//   Undefined    current instruction is undefined
//   IRQ          timer interrupt request (pulse or level)
//   PC           instruction fetch address
//   PCPlus4      PC + 4, used for the jal link
//   KernelMode   PC[31]
//   KWrite       register-file write of a return address this cycle
//   KAddr        26 ($k0, interrupt) or 27 ($k1, exception)
//   KData        return address to write
//   Squash       suppress the writes of the current instruction
//   IRQAck       one-cycle pulse when an interrupt is taken
//   Cause        0 user, 1 boot, 2 irq handler, 3 exc handler
//   KernelFault  sticky; set by an undefined instruction in kernel mode
//   IRQCount     (optional) taken interrupts, saturating at 16'hFFFF
//   IRQLost      (optional) sticky; an IRQ arrived while one was pending
// -----------------------------------------------------------------------------
module pc_controller #(
    parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
    parameter logic [31:0] IRQ_VECTOR   = 32'h8000_0004,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [15:0] Imm16,
    input  logic        Jump,
    input  logic [25:0] Target26,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    input  logic        Undefined,
    input  logic        IRQ,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        KernelMode,
    output logic        KWrite,
    output logic [4:0]  KAddr,
    output logic [31:0] KData,
    output logic        Squash,
    output logic        IRQAck,
    output logic [1:0]  Cause,
    output logic        KernelFault
`ifdef PC_CTRL_IRQ_COUNT_EN
    ,
    output logic [15:0] IRQCount,
    output logic        IRQLost
`endif
);

    logic [31:0] pc_reg, pc_next;
    logic [1:0]  cause_reg, cause_next;
    logic        pending_reg, pending_next;
    logic        kfault_reg, kfault_next;

    logic        kernel;
    logic        pend_now;
    logic        take_exc;
    logic        take_irq;
    logic        kernel_undef;
    logic [31:0] pc_plus4;
    logic [31:0] seq_target;
    logic [31:0] br_offset;
    logic [31:0] br_sum;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] jr_target;

    assign kernel   = pc_reg[31];
    assign pc_plus4 = pc_reg + 32'd4;

    // A request arriving this very cycle counts as pending, so an IRQ pulse
    // is taken at the same edge it is seen (unless stalled or in kernel).
    assign pend_now     = pending_reg | IRQ;
    assign take_exc     = !Stall && Undefined && !kernel;
    assign take_irq     = !Stall && !take_exc && pend_now && !kernel;
    assign kernel_undef = !Stall && Undefined && kernel;

    // Address arithmetic wraps inside the low 31 bits; bit31 (mode) is only
    // changed by the vectors or by a jr that drops to user mode.
    assign seq_target = {pc_reg[31], pc_plus4[30:0]};
    assign br_offset  = {{14{Imm16[15]}}, Imm16, 2'b00};
    assign br_sum     = pc_plus4 + br_offset;
    assign br_target  = {pc_reg[31], br_sum[30:0]};
    assign j_target   = {pc_reg[31:28], Target26, 2'b00};
    // User code can never set bit31 through a register jump.
    assign jr_target  = {pc_reg[31] & RegTarget[31], RegTarget[30:0]};

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_reg      <= RESET_VECTOR;
            cause_reg   <= 2'd1;
            pending_reg <= 1'b0;
            kfault_reg  <= 1'b0;
        end else begin
            pc_reg      <= pc_next;
            cause_reg   <= cause_next;
            pending_reg <= pending_next;
            kfault_reg  <= kfault_next;
        end
    end

    // Next-state selection
    always_comb begin
        pc_next      = pc_reg;
        cause_next   = cause_reg;
        pending_next = pend_now;
        kfault_next  = kfault_reg;
        if (!Stall) begin
            if (take_exc) begin
                // The interrupt (if any) stays pending across the exception.
                pc_next    = EXC_VECTOR;
                cause_next = 2'd3;
            end else if (take_irq) begin
                pc_next      = IRQ_VECTOR;
                cause_next   = 2'd2;
                pending_next = 1'b0;
            end else if (kernel_undef) begin
                // Kernel never vectors on itself: squash and step over it.
                pc_next     = seq_target;
                kfault_next = 1'b1;
            end else if (JumpReg) begin
                pc_next = jr_target;
                if (!jr_target[31]) begin
                    cause_next = 2'd0;
                end
            end else if (Jump) begin
                pc_next = j_target;
            end else if (Branch) begin
                pc_next = br_target;
            end else begin
                pc_next = seq_target;
            end
        end
    end

    // Outputs; the return-address write happens at the deciding edge.
    always_comb begin
        PC          = pc_reg;
        PCPlus4     = pc_plus4;
        KernelMode  = kernel;
        Cause       = cause_reg;
        KernelFault = kfault_reg;
        KWrite      = reset && (take_exc || take_irq);
        Squash      = reset && (take_exc || take_irq || kernel_undef);
        IRQAck      = reset && take_irq;
        KAddr       = 5'd0;
        KData       = 32'd0;
        if (take_exc) begin
            KAddr = 5'd27;
            KData = pc_plus4;
        end else if (take_irq) begin
            // Return to the interrupted instruction so it re-executes.
            KAddr = 5'd26;
            KData = pc_reg;
        end
    end

`ifdef PC_CTRL_IRQ_COUNT_EN
    logic [15:0] irq_count_reg;
    logic        irq_lost_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_count_reg <= 16'd0;
            irq_lost_reg  <= 1'b0;
        end else begin
            if (take_irq && (irq_count_reg != 16'hFFFF)) begin
                irq_count_reg <= irq_count_reg + 16'd1;
            end
            if (IRQ && pending_reg) begin
                irq_lost_reg <= 1'b1;
            end
        end
    end

    assign IRQCount = irq_count_reg;
    assign IRQLost  = irq_lost_reg;
`endif

endmodule

// File: tb/tb_pc_controller.sv
// -----------------------------------------------------------------------------
// tb_pc_controller
//
// Directed scenarios for boot, mode changes, interrupts, exceptions, branches,
// jumps and stalls, followed by a randomized run compared against a
// cycle-level reference model of the PC sequencer.
// -----------------------------------------------------------------------------
module tb_pc_controller;

    localparam logic [31:0] RV  = 32'h8000_0000;
    localparam logic [31:0] IV  = 32'h8000_0004;
    localparam logic [31:0] EV  = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Branch;
    logic [15:0] Imm16;
    logic        Jump;
    logic [25:0] Target26;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic        Undefined;
    logic        IRQ;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        KernelMode;
    logic        KWrite;
    logic [4:0]  KAddr;
    logic [31:0] KData;
    logic        Squash;
    logic        IRQAck;
    logic [1:0]  Cause;
    logic        KernelFault;
`ifdef PC_CTRL_IRQ_COUNT_EN
    logic [15:0] IRQCount;
    logic        IRQLost;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_controller dut (
        .clk         (clk),
        .reset       (reset),
        .Stall       (Stall),
        .Branch      (Branch),
        .Imm16       (Imm16),
        .Jump        (Jump),
        .Target26    (Target26),
        .JumpReg     (JumpReg),
        .RegTarget   (RegTarget),
        .Undefined   (Undefined),
        .IRQ         (IRQ),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .KernelMode  (KernelMode),
        .KWrite      (KWrite),
        .KAddr       (KAddr),
        .KData       (KData),
        .Squash      (Squash),
        .IRQAck      (IRQAck),
        .Cause       (Cause),
        .KernelFault (KernelFault)
`ifdef PC_CTRL_IRQ_COUNT_EN
        ,
        .IRQCount    (IRQCount),
        .IRQLost     (IRQLost)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Stall = 0; Branch = 0; Imm16 = 16'h0; Jump = 0; Target26 = 26'h0;
        JumpReg = 0; RegTarget = 32'h0; Undefined = 0; IRQ = 0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
    endtask

    // Move into user mode at addr via a jr issued from kernel mode.
    task automatic goto_user(input logic [31:0] addr);
        apply_reset();
        JumpReg = 1; RegTarget = addr;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 0; Undefined = 1; IRQ = 1;
        tick();
        checks++; if (Squash !== 1'b0) begin failures++; $display("FAIL reset_squash: got %b expected 0", Squash); end
        checks++; if (KWrite !== 1'b0 || IRQAck !== 1'b0) begin failures++; $display("FAIL reset_kwrite_ack: got %b%b expected 00", KWrite, IRQAck); end
        tick();
        idle_inputs();
        reset = 1;
        checks++; if (PC !== RV) begin failures++; $display("FAIL boot_pc0: got %h expected %h", PC, RV); end
        checks++; if (KernelMode !== 1'b1 || Cause !== 2'd1) begin failures++; $display("FAIL boot_mode: got km=%b cause=%0d expected km=1 cause=1", KernelMode, Cause); end
        checks++; if (KernelFault !== 1'b0) begin failures++; $display("FAIL boot_kfault: got %b expected 0", KernelFault); end
        tick();
        checks++; if (PC !== 32'h8000_0004) begin failures++; $display("FAIL boot_pc1: got %h expected 80000004", PC); end
        tick();
        checks++; if (PC !== 32'h8000_0008) begin failures++; $display("FAIL boot_pc2: got %h expected 80000008", PC); end
        $display("test_reset: boot sequence PC=%h", PC);
    endtask

    task automatic test_leave_kernel();
        apply_reset();
        JumpReg = 1; RegTarget = 32'h0000_00B4;
        tick();
        idle_inputs();
        checks++; if (PC !== 32'h0000_00B4) begin failures++; $display("FAIL leave_pc: got %h expected 000000b4", PC); end
        checks++; if (KernelMode !== 1'b0 || Cause !== 2'd0) begin failures++; $display("FAIL leave_mode: got km=%b cause=%0d expected km=0 cause=0", KernelMode, Cause); end
        #1;
        // Reset must have left nothing pending.
        checks++; if (KWrite !== 1'b0) begin failures++; $display("FAIL leave_no_pending: got KWrite=%b expected 0", KWrite); end
        tick();
        checks++; if (PC !== 32'h0000_00B8) begin failures++; $display("FAIL leave_seq: got %h expected 000000b8", PC); end
        $display("test_leave_kernel: PC=%h", PC);
    endtask

    task automatic test_no_escalate();
        goto_user(32'h0000_00C0);
        JumpReg = 1; RegTarget = 32'h8000_0010;
        tick();
        idle_inputs();
        checks++; if (PC !== 32'h0000_0010 || KernelMode !== 1'b0) begin failures++; $display("FAIL no_escalate: got %h expected 00000010", PC); end
        // User-mode wrap: bit31 must not be set by the carry.
        JumpReg = 1; RegTarget = 32'h7FFF_FFFC;
        tick();
        idle_inputs();
        tick();
        checks++; if (PC !== 32'h0000_0000) begin failures++; $display("FAIL user_wrap: got %h expected 00000000", PC); end
        // Kernel wrap stays in kernel.
        apply_reset();
        JumpReg = 1; RegTarget = 32'hFFFF_FFFC;
        tick();
        idle_inputs();
        checks++; if (PC !== 32'hFFFF_FFFC) begin failures++; $display("FAIL kernel_jr: got %h expected fffffffc", PC); end
        tick();
        checks++; if (PC !== 32'h8000_0000) begin failures++; $display("FAIL kernel_wrap: got %h expected 80000000", PC); end
        $display("test_no_escalate: PC=%h", PC);
    endtask

    task automatic test_interrupt();
        goto_user(32'h0000_0120);
        IRQ = 1;
        #1;
        checks++; if (KWrite !== 1'b1 || KAddr !== 5'd26) begin failures++; $display("FAIL irq_kwrite: got %b/%0d expected 1/26", KWrite, KAddr); end
        checks++; if (KData !== 32'h0000_0120) begin failures++; $display("FAIL irq_kdata: got %h expected 00000120", KData); end
        checks++; if (IRQAck !== 1'b1 || Squash !== 1'b1) begin failures++; $display("FAIL irq_ack_squash: got %b%b expected 11", IRQAck, Squash); end
        tick();
        IRQ = 0;
        checks++; if (PC !== IV || Cause !== 2'd2) begin failures++; $display("FAIL irq_vector: got %h cause %0d expected %h cause 2", PC, Cause, IV); end
        IRQ = 1;
        #1;
        checks++; if (IRQAck !== 1'b0 || KWrite !== 1'b0) begin failures++; $display("FAIL irq_nested: got ack=%b kw=%b expected 0 0", IRQAck, KWrite); end
        tick();
        IRQ = 0;
        checks++; if (PC !== 32'h8000_0008) begin failures++; $display("FAIL irq_handler_seq: got %h expected 80000008", PC); end
        JumpReg = 1; RegTarget = 32'h0000_0120;
        tick();
        idle_inputs();
        #1;
        checks++; if (PC !== 32'h0000_0120 || Cause !== 2'd0) begin failures++; $display("FAIL irq_return: got %h cause %0d expected 00000120 cause 0", PC, Cause); end
        checks++; if (IRQAck !== 1'b1 || KData !== 32'h0000_0120) begin failures++; $display("FAIL irq_revector: got ack=%b kdata=%h expected 1 00000120", IRQAck, KData); end
        tick();
        checks++; if (PC !== IV) begin failures++; $display("FAIL irq_revector_pc: got %h expected %h", PC, IV); end
        $display("test_interrupt: PC=%h", PC);
    endtask

    task automatic test_exception_priority();
        goto_user(32'h0000_0200);
        // Latch the interrupt during a stall so it is pending alongside Undefined.
        Stall = 1; IRQ = 1;
        tick();
        Stall = 0; IRQ = 0; Undefined = 1;
        #1;
        checks++; if (KWrite !== 1'b1 || KAddr !== 5'd27 || KData !== 32'h0000_0204) begin failures++; $display("FAIL exc_kwrite: got %b/%0d/%h expected 1/27/00000204", KWrite, KAddr, KData); end
        checks++; if (Squash !== 1'b1 || IRQAck !== 1'b0) begin failures++; $display("FAIL exc_squash_ack: got %b%b expected 10", Squash, IRQAck); end
        tick();
        checks++; if (PC !== EV || Cause !== 2'd3) begin failures++; $display("FAIL exc_vector: got %h cause %0d expected %h cause 3", PC, Cause, EV); end
        #1;
        checks++; if (Squash !== 1'b1 || KWrite !== 1'b0) begin failures++; $display("FAIL kundef_squash: got sq=%b kw=%b expected 1 0", Squash, KWrite); end
        tick();
        Undefined = 0;
        checks++; if (KernelFault !== 1'b1 || PC !== 32'h8000_000C) begin failures++; $display("FAIL kundef_fault: got kf=%b pc=%h expected 1 8000000c", KernelFault, PC); end
        JumpReg = 1; RegTarget = 32'h0000_0204;
        tick();
        idle_inputs();
        #1;
        checks++; if (IRQAck !== 1'b1 || KAddr !== 5'd26 || KData !== 32'h0000_0204) begin failures++; $display("FAIL exc_pending_kept: got %b/%0d/%h expected 1/26/00000204", IRQAck, KAddr, KData); end
        tick();
        $display("test_exception_priority: PC=%h", PC);
    endtask

    task automatic test_branch_jump_stall();
        apply_reset();
        Jump = 1; Target26 = 26'd3;
        tick();
        idle_inputs();
        checks++; if (PC !== 32'h8000_000C) begin failures++; $display("FAIL kernel_jump: got %h expected 8000000c", PC); end
        JumpReg = 1; RegTarget = 32'h0000_0100;
        tick();
        idle_inputs();
        Branch = 1; Imm16 = 16'hFFFC;
        tick();
        checks++; if (PC !== 32'h0000_00F4) begin failures++; $display("FAIL branch_back: got %h expected 000000f4", PC); end
        for (int i = 0; i < 3; i++) begin
            Stall = 1; Branch = 1; IRQ = (i == 1);
            #1;
            checks++; if (KWrite !== 1'b0 || Squash !== 1'b0 || IRQAck !== 1'b0) begin failures++; $display("FAIL stall_outputs: got %b%b%b expected 000", KWrite, Squash, IRQAck); end
            tick();
            checks++; if (PC !== 32'h0000_00F4) begin failures++; $display("FAIL stall_hold: got %h expected 000000f4", PC); end
        end
        idle_inputs();
        #1;
        checks++; if (IRQAck !== 1'b1 || KData !== 32'h0000_00F4) begin failures++; $display("FAIL stall_irq: got ack=%b kdata=%h expected 1 000000f4", IRQAck, KData); end
        tick();
        checks++; if (PC !== IV) begin failures++; $display("FAIL stall_irq_pc: got %h expected %h", PC, IV); end
        $display("test_branch_jump_stall: PC=%h", PC);
    endtask

    task automatic test_random(input int n);
        logic [31:0] m_pc, n_pc, e_kdata, tgt;
        logic [1:0]  m_cause, n_cause;
        logic        m_pend, n_pend, m_kf, n_kf;
        logic        e_kwrite, e_squash, e_ack, now_pend, kern;
        logic [4:0]  e_kaddr;
        int          off;
`ifdef PC_CTRL_IRQ_COUNT_EN
        int          m_count;
        logic        m_lost;
        m_count = 0; m_lost = 0;
`endif
        apply_reset();
        m_pc = RV; m_cause = 2'd1; m_pend = 0; m_kf = 0;
        for (int i = 0; i < n; i++) begin
            reset     = ($urandom_range(0, 49) != 0);
            Stall     = ($urandom_range(0, 7) == 0);
            Undefined = ($urandom_range(0, 9) == 0);
            IRQ       = ($urandom_range(0, 9) == 0);
            JumpReg   = ($urandom_range(0, 5) == 0);
            Jump      = ($urandom_range(0, 5) == 0);
            Branch    = ($urandom_range(0, 3) == 0);
            Imm16     = 16'($urandom);
            Target26  = 26'($urandom);
            RegTarget = $urandom;
            #1;
            kern = m_pc[31];
            now_pend = m_pend || IRQ;
            e_kwrite = 0; e_squash = 0; e_ack = 0; e_kaddr = 0; e_kdata = 0;
            n_pc = m_pc; n_cause = m_cause; n_pend = now_pend; n_kf = m_kf;
            if (!reset) begin
                n_pc = RV; n_cause = 2'd1; n_pend = 0; n_kf = 0;
            end else if (!Stall) begin
                if (Undefined && !kern) begin
                    e_kwrite = 1; e_squash = 1; e_kaddr = 27; e_kdata = m_pc + 4;
                    n_pc = EV; n_cause = 3;
                end else if (now_pend && !kern) begin
                    e_kwrite = 1; e_squash = 1; e_ack = 1; e_kaddr = 26; e_kdata = m_pc;
                    n_pc = IV; n_cause = 2; n_pend = 0;
                end else if (Undefined) begin
                    e_squash = 1; n_kf = 1;
                    n_pc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
                end else if (JumpReg) begin
                    tgt = RegTarget;
                    if (!kern) tgt = tgt & 32'h7FFF_FFFF;
                    n_pc = tgt;
                    if (tgt < 32'h8000_0000) n_cause = 0;
                end else if (Jump) begin
                    n_pc = (m_pc & 32'hF000_0000) | (32'(Target26) * 4);
                end else if (Branch) begin
                    off = int'($signed(Imm16)) * 4;
                    n_pc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4 + 32'(off)) & 32'h7FFF_FFFF);
                end else begin
                    n_pc = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
                end
            end
            checks++; if (KWrite !== e_kwrite || Squash !== e_squash || IRQAck !== e_ack) begin failures++; $display("FAIL rnd_ctrl[%0d]: got kw/sq/ack=%b%b%b expected %b%b%b", i, KWrite, Squash, IRQAck, e_kwrite, e_squash, e_ack); end
            if (e_kwrite) begin
                checks++; if (KAddr !== e_kaddr || KData !== e_kdata) begin failures++; $display("FAIL rnd_kret[%0d]: got %0d/%h expected %0d/%h", i, KAddr, KData, e_kaddr, e_kdata); end
            end
            checks++; if (PCPlus4 !== m_pc + 32'd4 || KernelMode !== kern) begin failures++; $display("FAIL rnd_pcplus4[%0d]: got %h km=%b expected %h km=%b", i, PCPlus4, KernelMode, m_pc + 32'd4, kern); end
`ifdef PC_CTRL_IRQ_COUNT_EN
            if (!reset) begin
                m_count = 0; m_lost = 0;
            end else begin
                if (e_ack && m_count < 65535) m_count++;
                if (IRQ && m_pend) m_lost = 1;
            end
`endif
            tick();
            m_pc = n_pc; m_cause = n_cause; m_pend = n_pend; m_kf = n_kf;
            checks++; if (PC !== m_pc || Cause !== m_cause || KernelFault !== m_kf) begin failures++; $display("FAIL rnd_state[%0d]: got pc=%h c=%0d kf=%b expected pc=%h c=%0d kf=%b", i, PC, Cause, KernelFault, m_pc, m_cause, m_kf); end
`ifdef PC_CTRL_IRQ_COUNT_EN
            checks++; if (IRQCount !== 16'(m_count) || IRQLost !== m_lost) begin failures++; $display("FAIL rnd_count[%0d]: got %0d/%b expected %0d/%b", i, IRQCount, IRQLost, m_count, m_lost); end
`endif
            $display("rnd %0d: pc=%h cause=%0d kf=%b", i, PC, Cause, KernelFault);
        end
        reset = 1;
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_leave_kernel();
        test_no_escalate();
        test_interrupt();
        test_exception_priority();
        test_branch_jump_stall();
        test_random(300);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
Name: pc_controller

Overview:
- Program-counter sequencer for the single-cycle MIPS core. Drives the instruction-memory Address each cycle.
- Selects the next PC from these sources: sequential, branch, jump, jr, reset vector, interrupt vector, exception vector.
- Tracks kernel (supervisor) mode in PC[31], latches timer interrupts, and supplies the $k0/$k1 return-address write for the register file.

Parameters:
- RESET_VECTOR, 32'h80000000, PC after reset.
- IRQ_VECTOR, 32'h80000004, interrupt handler entry.
- EXC_VECTOR, 32'h80000008, undefined-instruction handler entry.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-low reset.
- Stall  input  1  hold PC; no state change except IRQ latching.
- Branch  input  1  conditional branch taken (decode + ALU result).
- Imm16  input  16  branch offset field.
- Jump  input  1  j/jal.
- Target26  input  26  jump field.
- JumpReg  input  1  jr/jalr.
- RegTarget  input  32  rs value for jr.
- Undefined  input  1  decoder flags current instruction as undefined.
- IRQ  input  1  timer interrupt request (pulse or level).
- PC  output  32  instruction fetch address.
- PCPlus4  output  32  PC+4, for jal link.
- KernelMode  output  1  equals PC[31].
- KWrite  output  1  register-file write of return address this cycle.
- KAddr  output  5  26 ($k0) or 27 ($k1).
- KData  output  32  return address to write.
- Squash  output  1  suppress register/memory writes of the current instruction.
- IRQAck  output  1  one-cycle pulse when an interrupt is taken.
- Cause  output  2  0 user, 1 boot, 2 irq handler, 3 exc handler.
- KernelFault  output  1  sticky; set by Undefined while in kernel.

Behaviour:
- Reset (reset==0 at a clk edge):
  - PC=RESET_VECTOR, Cause=1, pending=0, KernelFault=0.
  - KWrite, Squash and IRQAck are 0 while reset is asserted.
- PCPlus4 = PC+4, combinational.
- The PC register updates every edge unless Stall=1.
- pending latch:
  - Set on any cycle with IRQ=1, including stalled cycles.
  - Cleared when the interrupt is taken, or on reset.
- Next-PC priority, highest first (evaluated only when Stall=0):
  1. Undefined && !PC[31]: PC<=EXC_VECTOR, KWrite=1, KAddr=27, KData=PCPlus4, Squash=1, Cause<=3.
  2. pending && !PC[31]: PC<=IRQ_VECTOR, KWrite=1, KAddr=26, KData=PC (the current instruction is re-executed on return), Squash=1, IRQAck=1, pending<=0, Cause<=2.
  3. JumpReg: PC<=RegTarget with bit31 forced to PC[31] & RegTarget[31]. User code can never enter kernel. If the new bit31 is 0, Cause<=0.
  4. Jump: PC<={PC[31:28], Target26, 2'b00}.
  5. Branch: PC<={PC[31], (PCPlus4 + sext(Imm16)<<2)[30:0]}.
  6. Otherwise: PC<=PCPlus4, with bit31 preserved.
- Kernel mode (PC[31]=1):
  - IRQs stay pending and are not nested.
  - Undefined does not vector. The instruction is squashed, PC advances normally, and KernelFault is set.
- Simultaneous Undefined and pending in user mode: the exception is taken and pending stays set. The IRQ is taken on the first user-mode cycle after return.
- Stall=1:
  - KWrite, Squash and IRQAck are 0.
  - PC and Cause hold.
  - The IRQ is still latched.
- Arithmetic wraps at 31 bits; carry into bit31 is discarded.
- Reset mid-handler returns to RESET_VECTOR; pending and Cause are reinitialised.
- Latency:
  - The new PC is visible the cycle after the deciding edge.
  - KWrite/KData are combinational in the deciding cycle, for write at that edge.

Optional Feature:
- Macro PC_CTRL_IRQ_COUNT_EN.
- When defined:
  - Adds output IRQCount[15:0], reset to 0.
  - Increments on every IRQAck and saturates at 16'hFFFF.
  - Adds output IRQLost, a sticky flag set when IRQ=1 arrives while pending is already 1.
- When undefined, neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset and boot: hold reset=0 for 2 cycles, then release.
  - PC=80000000, then 80000004 and 80000008 sequentially.
  - KernelMode=1, Cause=1.
- Leaving kernel: in kernel, JumpReg with RegTarget=000000B4.
  - Next PC=000000B4, KernelMode=0, Cause=0.
- User cannot escalate: from user PC 000000C0, JumpReg with RegTarget=80000010.
  - Next PC=00000010.
- Interrupt:
  - One-cycle IRQ pulse at user PC=00000120.
  - Next PC=80000004, with KWrite=1, KAddr=26, KData=00000120, IRQAck=1, Squash=1.
  - A second IRQ while in the handler stays pending.
  - After jr $k0 to 00000120, the interrupt vectors again one cycle later.
- Exception priority: Undefined=1 and pending=1 together at PC=00000200.
  - PC=80000008, KAddr=27, KData=00000204, pending retained.
  - Kernel Undefined sets KernelFault.
- Branch/jump with stall:
  - Branch at PC=00000100 with Imm16=FFFC gives PC=000000F4.
  - Jump with Target26=3 in kernel gives PC=8000000C.
  - Stall=1 for 3 cycles holds PC, and an IRQ pulse during the stall is taken after the stall ends.
